// File: rtl/kon2_io_mapper.sv
// Konami-2 bus I/O mapper.
// Decodes an 8-byte window behind BASE_ADDR, inserts WAIT_STATES extra cycles,
// then acknowledges with DTAC. Writes go to six output registers; reads return
// a register byte or one of the two input ports.
module kon2_io_mapper #(
  parameter logic [15:0] BASE_ADDR   = 16'h5F80,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [15:0] ADDR,
  input  logic        AS,
  input  logic        RWn,
  input  logic [7:0]  DB_IN,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  output logic        DTAC,
  input  logic [7:0]  IN_A,
  input  logic [7:0]  IN_B,
  output logic [47:0] REG_Q,
  output logic        WR_STB,
  output logic [2:0]  WR_IDX
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        as_q;
  logic [2:0]  idx_q, idx_d;
  logic        rd_q, rd_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dtac_q, dtac_d;
  logic        oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic [47:0] reg_q, reg_d;
  logic        stb_q, stb_d;
  logic [2:0]  wr_idx_q, wr_idx_d;

  logic        cycle_start;
  logic        win_hit;
  logic [7:0]  rd_mux;

  // A cycle starts only on a falling AS; a held-low AS never restarts.
  assign cycle_start = ~AS & as_q;
  assign win_hit     = (ADDR[15:3] == BASE_ADDR[15:3]);

  assign DB_OUT = dout_q;
  assign DB_OE  = oe_q;
  assign DTAC   = dtac_q;
  assign REG_Q  = reg_q;
  assign WR_STB = stb_q;
  assign WR_IDX = wr_idx_q;

  // Read data source for the latched index; ports are sampled when ACK is entered.
  always_comb begin
    rd_mux = reg_q[{idx_q, 3'b000} +: 8];
    case (idx_q)
      3'd6:    rd_mux = IN_A;
      3'd7:    rd_mux = IN_B;
      default: rd_mux = reg_q[{idx_q, 3'b000} +: 8];
    endcase
  end

  // Next-state and output logic of the access sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    dtac_d   = dtac_q;
    oe_d     = oe_q;
    dout_d   = dout_q;
    reg_d    = reg_q;
    stb_d    = 1'b0;
    wr_idx_d = wr_idx_q;

    case (state_q)
      S_IDLE: begin
        if (cycle_start && win_hit) begin
          // Address, direction and write data are frozen here for the whole access.
          idx_d   = ADDR[2:0];
          rd_d    = RWn;
          wdata_d = DB_IN;
          cnt_d   = WS_CNT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (AS) begin
          // CPU gave up the cycle before acknowledge: drop it silently.
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          dtac_d  = 1'b0;
          if (rd_q) begin
            dout_d = rd_mux;
            oe_d   = 1'b1;
          end else if (idx_q <= 3'd5) begin
            reg_d[{idx_q, 3'b000} +: 8] = wdata_q;
            stb_d    = 1'b1;
            wr_idx_d = idx_q;
          end
          // Writes to the input-port indices are acknowledged but discarded.
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        if (AS) begin
          state_d = S_IDLE;
          dtac_d  = 1'b1;
          oe_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        dtac_d  = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= S_IDLE;
      as_q     <= 1'b1;
      idx_q    <= 3'd0;
      rd_q     <= 1'b0;
      wdata_q  <= 8'h00;
      cnt_q    <= 4'd0;
      dtac_q   <= 1'b1;
      oe_q     <= 1'b0;
      dout_q   <= 8'h00;
      reg_q    <= 48'h0;
      stb_q    <= 1'b0;
      wr_idx_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      as_q     <= AS;
      idx_q    <= idx_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      dtac_q   <= dtac_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      reg_q    <= reg_d;
      stb_q    <= stb_d;
      wr_idx_q <= wr_idx_d;
    end
  end

endmodule

// File: tb/tb_kon2_io_mapper.sv
// Directed bench for kon2_io_mapper with WAIT_STATES=2.
module tb_kon2_io_mapper;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic        AS = 1'b1;
  logic        RWn = 1'b1;
  logic [7:0]  DB_IN = 8'h00;
  logic [7:0]  DB_OUT;
  logic        DB_OE;
  logic        DTAC;
  logic [7:0]  IN_A = 8'h00;
  logic [7:0]  IN_B = 8'h00;
  logic [47:0] REG_Q;
  logic        WR_STB;
  logic [2:0]  WR_IDX;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  kon2_io_mapper #(.BASE_ADDR(16'h5F80), .WAIT_STATES(2)) dut (
    .CLK(CLK), .RES(RES), .ADDR(ADDR), .AS(AS), .RWn(RWn), .DB_IN(DB_IN),
    .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DTAC(DTAC), .IN_A(IN_A), .IN_B(IN_B),
    .REG_Q(REG_Q), .WR_STB(WR_STB), .WR_IDX(WR_IDX)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    logic        rwn;
    logic [7:0]  din;
    bit          exp_ack;
    logic [7:0]  exp_dout;
    int          exp_stb;
    logic [2:0]  exp_idx;
    logic [47:0] exp_reg;
    string       nm;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One complete bus cycle; ADDR/RWn/DB_IN are scrambled after decode.
  task automatic access(input vec_t v);
    int  n = 0;
    int  stb = 0;
    bit  acked = 0;
    bit  oe_early = 0;
    bit  dtac_drop = 0;
    ADDR = v.addr; RWn = v.rwn; DB_IN = v.din; AS = 1'b0;
    while (!acked && n < 10) begin
      @(posedge CLK); #1;
      n++;
      if (WR_STB) stb++;
      if (DTAC == 1'b0) acked = 1;
      else if (DB_OE) oe_early = 1;
      if (n == 1) begin
        ADDR = 16'h0000; RWn = ~v.rwn; DB_IN = ~v.din;
      end
    end
    chk({v.nm, " ack"}, 48'(acked), 48'(v.exp_ack));
    chk({v.nm, " oe_before_ack"}, 48'(oe_early), 48'd0);
    if (v.exp_ack) begin
      chk({v.nm, " latency"}, 48'(n), 48'd4);
      chk({v.nm, " db_oe"}, 48'(DB_OE), 48'(v.rwn));
      if (v.rwn) chk({v.nm, " db_out"}, 48'(DB_OUT), 48'(v.exp_dout));
    end
    repeat (2) begin
      @(posedge CLK); #1;
      if (WR_STB) stb++;
      if (DTAC != !v.exp_ack) dtac_drop = 1;
    end
    chk({v.nm, " dtac_hold"}, 48'(dtac_drop), 48'd0);
    chk({v.nm, " wr_stb_count"}, 48'(stb), 48'(v.exp_stb));
    if (v.exp_stb > 0) chk({v.nm, " wr_idx"}, 48'(WR_IDX), 48'(v.exp_idx));
    AS = 1'b1;
    @(posedge CLK); #1;
    chk({v.nm, " dtac_release"}, 48'(DTAC), 48'd1);
    chk({v.nm, " oe_release"}, 48'(DB_OE), 48'd0);
    if (v.exp_ack && v.rwn) chk({v.nm, " db_out_retained"}, 48'(DB_OUT), 48'(v.exp_dout));
    chk({v.nm, " reg_q"}, REG_Q, v.exp_reg);
    $display("access %s addr=%h rwn=%0d ack=%0d lat=%0d stb=%0d reg=%h", v.nm, v.addr, v.rwn, acked, n, stb, REG_Q);
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic r, input logic [7:0] d,
                              input bit ack, input logic [7:0] dout, input int stb,
                              input logic [2:0] idx, input logic [47:0] rg, input string nm);
    vec_t v;
    v.addr = a; v.rwn = r; v.din = d; v.exp_ack = ack; v.exp_dout = dout;
    v.exp_stb = stb; v.exp_idx = idx; v.exp_reg = rg; v.nm = nm;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   n;
    bit   bad;

    vecs[0]  = mk(16'h5F82, 1'b0, 8'h1A, 1, 8'h00, 1, 3'd2, 48'h0000_001A_0000, "wr_5F82");
    vecs[1]  = mk(16'h5F82, 1'b1, 8'h00, 1, 8'h1A, 0, 3'd0, 48'h0000_001A_0000, "rd_5F82");
    vecs[2]  = mk(16'h5F86, 1'b1, 8'h00, 1, 8'h5C, 0, 3'd0, 48'h0000_001A_0000, "rd_in_a");
    vecs[3]  = mk(16'h5F87, 1'b1, 8'h00, 1, 8'hA3, 0, 3'd0, 48'h0000_001A_0000, "rd_in_b");
    vecs[4]  = mk(16'h5F87, 1'b0, 8'hFF, 1, 8'h00, 0, 3'd0, 48'h0000_001A_0000, "wr_5F87_discard");
    vecs[5]  = mk(16'h5F88, 1'b1, 8'h00, 0, 8'h00, 0, 3'd0, 48'h0000_001A_0000, "rd_5F88_miss");
    vecs[6]  = mk(16'h5F88, 1'b0, 8'hAA, 0, 8'h00, 0, 3'd0, 48'h0000_001A_0000, "wr_5F88_miss");
    vecs[7]  = mk(16'h0000, 1'b1, 8'h00, 0, 8'h00, 0, 3'd0, 48'h0000_001A_0000, "rd_0000_miss");
    vecs[8]  = mk(16'h0000, 1'b0, 8'h55, 0, 8'h00, 0, 3'd0, 48'h0000_001A_0000, "wr_0000_miss");
    vecs[9]  = mk(16'h5F85, 1'b0, 8'hAB, 1, 8'h00, 1, 3'd5, 48'hAB00_001A_0000, "wr_5F85");
    vecs[10] = mk(16'h5F85, 1'b1, 8'h00, 1, 8'hAB, 0, 3'd0, 48'hAB00_001A_0000, "rd_5F85");

    // Reset values, checked asynchronously before any clock edge.
    #1 RES = 1'b1;
    #1;
    chk("rst dtac", 48'(DTAC), 48'd1);
    chk("rst db_oe", 48'(DB_OE), 48'd0);
    chk("rst db_out", 48'(DB_OUT), 48'd0);
    chk("rst reg_q", REG_Q, 48'd0);
    chk("rst wr_stb", 48'(WR_STB), 48'd0);
    chk("rst wr_idx", 48'(WR_IDX), 48'd0);
    repeat (2) @(posedge CLK);
    #1 RES = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    IN_A = 8'h5C; IN_B = 8'hA3;

    for (int i = 0; i < 11; i++) access(vecs[i]);

    // Abort in WAIT after one cycle: no acknowledge, no write.
    ADDR = 16'h5F80; RWn = 1'b0; DB_IN = 8'h55; AS = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    AS = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (DTAC != 1'b1 || WR_STB) bad = 1;
    end
    chk("abort no_ack_no_stb", 48'(bad), 48'd0);
    chk("abort reg_q", REG_Q, 48'hAB00_001A_0000);
    $display("abort addr=5F80 reg=%h", REG_Q);
    access(mk(16'h5F80, 1'b0, 8'h33, 1, 8'h00, 1, 3'd0, 48'hAB00_001A_0033, "wr_5F80_after_abort"));

    // Reset pulsed while held in ACK.
    ADDR = 16'h5F85; RWn = 1'b0; DB_IN = 8'h77; AS = 1'b0;
    n = 0;
    while (DTAC != 1'b0 && n < 10) begin @(posedge CLK); #1; n++; end
    chk("rst_in_ack acked", 48'(DTAC), 48'd0);
    chk("rst_in_ack reg5", 48'(REG_Q[47:40]), 48'h77);
    #2 RES = 1'b1;
    #1;
    chk("rst_in_ack dtac", 48'(DTAC), 48'd1);
    chk("rst_in_ack db_oe", 48'(DB_OE), 48'd0);
    chk("rst_in_ack reg_q", REG_Q, 48'd0);
    chk("rst_in_ack wr_stb", 48'(WR_STB), 48'd0);
    $display("reset_in_ack dtac=%0d reg=%h", DTAC, REG_Q);
    #2 AS = 1'b1; RES = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Back-to-back writes with a one-cycle AS-high gap.
    access(mk(16'h5F80, 1'b0, 8'h01, 1, 8'h00, 1, 3'd0, 48'h0000_0000_0001, "b2b_wr_5F80"));
    access(mk(16'h5F81, 1'b0, 8'h02, 1, 8'h00, 1, 3'd1, 48'h0000_0000_0201, "b2b_wr_5F81"));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
